// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: shared types and constants for the AFE serial-port shifter.
//   spi_state_e  - transfer FSM states
//   BUSY/OVERRUN/CHAN_LSB - status word bit positions
//   CLR_OVR/CHAN_W       - CSR write-data fields
//   half_cycles()        - sysClk cycles per SPI half period, ceil, minimum 1
package afe_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_LE_HI,
    ST_LE_HOLD
  } spi_state_e;

  localparam int unsigned BUSY     = 31;
  localparam int unsigned OVERRUN  = 30;
  localparam int unsigned CHAN_LSB = 24;
  localparam int unsigned CLR_OVR  = 31;
  localparam int unsigned CHAN_W   = 4;

  // ceil(clk_rate / (2*spi_rate)), never below 1
  function automatic int unsigned half_cycles(input longint unsigned clk_rate,
                                              input longint unsigned spi_rate);
    longint unsigned den;
    longint unsigned h;
    den = 64'd2 * spi_rate;
    if (den == 64'd0) return 1;
    h = (clk_rate + den - 64'd1) / den;
    if (h < 64'd1) h = 64'd1;
    return 32'(h);
  endfunction

endpackage

// File: rtl/afe_spi_tick.sv
// afe_spi_tick: reloadable down-counter that flags the last cycle of each
// PERIOD-cycle interval.
//   clk_i, rst_i  - clock, synchronous active-high reset (counter -> PERIOD-1)
//   load_i        - restart the interval (counter -> PERIOD-1), suppresses tick
//   en_i          - count enable
//   tick_c_o      - combinational, high while enabled and the counter is 0
module afe_spi_tick #(
  parameter int unsigned PERIOD = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tick_c_o
);

  localparam int unsigned   CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count HALF-1 down to 0, then wrap back to the reload value
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

  assign tick_c_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/afe_spi_shifter.sv
// afe_spi_shifter: shifts a CSR-written word MSB first onto one of the AFE
// serial ports, then pulses that port's latch enable.
//   sysClk, sysReset - clock, synchronous active-high reset
//   sysCsrStrobe     - one-cycle write strobe
//   sysGPIO_OUT      - [WORD_WIDTH-1:0] word, [27:24] channel, [31] clear overrun
//   status           - [31] busy, [30] overrun, [27:24] channel, [W-1:0] last word
//   spiClk/Sdi/Le    - per-channel AFE serial port, idle low
// Optional: `define AFE_SPI_REFRESH_EN to periodically resend the last word
// written to each channel every REFRESH_CYCLES sysClk cycles.
module afe_spi_shifter
  import afe_spi_pkg::*;
#(
  parameter int unsigned CLK_RATE       = 99999001,
  parameter int unsigned SPI_RATE       = 10000000,
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned CHANNEL_COUNT  = 2,
  parameter int unsigned REFRESH_CYCLES = 100000000
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  input  logic                     sysCsrStrobe,
  input  logic [31:0]              sysGPIO_OUT,
  output logic [31:0]              status,
  output logic [CHANNEL_COUNT-1:0] spiClk,
  output logic [CHANNEL_COUNT-1:0] spiSdi,
  output logic [CHANNEL_COUNT-1:0] spiLe
);

  localparam int unsigned HALF  = half_cycles(CLK_RATE, SPI_RATE);
  localparam int unsigned BIT_W = $clog2(WORD_WIDTH + 1);

  if (CHANNEL_COUNT < 1 || CHANNEL_COUNT > 16 || WORD_WIDTH < 1 ||
      WORD_WIDTH > 24 || REFRESH_CYCLES < 2) begin : g_cfg_err
    $error("afe_spi_shifter: unsupported parameter set");
  end

  spi_state_e               state_q, state_d;
  logic [WORD_WIDTH-1:0]    shreg_q, shreg_d;
  logic [WORD_WIDTH-1:0]    word_q, word_d;
  logic [CHAN_W-1:0]        ch_q, ch_d;
  logic [CHANNEL_COUNT-1:0] sel_q, sel_d;
  logic [BIT_W-1:0]         bits_q, bits_d;
  logic                     ovr_q, ovr_d;
  logic [CHANNEL_COUNT-1:0] clk_q, clk_d, sdi_q, sdi_d, le_q, le_d;
  logic [31:0]              status_q, status_d;

  logic [CHAN_W-1:0]        wr_chan_c;
  logic [WORD_WIDTH-1:0]    wr_word_c;
  logic                     wr_clr_c, chan_ok_c, busy_c, accept_c, drop_c;
  logic                     start_c, tick_c;

  logic                     rf_busy_c, rf_busy_d, rf_start_c;
  logic [CHAN_W-1:0]        rf_idx_c;
  logic [WORD_WIDTH-1:0]    rf_word_c;
  logic                     unused_gpio;

  // CSR write decode
  assign wr_chan_c   = sysGPIO_OUT[CHAN_LSB +: CHAN_W];
  assign wr_word_c   = sysGPIO_OUT[WORD_WIDTH-1:0];
  assign wr_clr_c    = sysGPIO_OUT[CLR_OVR];
  assign chan_ok_c   = (32'(wr_chan_c) < CHANNEL_COUNT);
  assign unused_gpio = ^sysGPIO_OUT;

  // A refresh sequence counts as busy even in the IDLE gap between its transfers
  assign busy_c   = (state_q != ST_IDLE) || rf_busy_c;
  assign accept_c = sysCsrStrobe && !busy_c && chan_ok_c;
  assign drop_c   = sysCsrStrobe && !accept_c;
  assign start_c  = accept_c || rf_start_c;

  afe_spi_tick #(
    .PERIOD (HALF)
  ) u_half_tick (
    .clk_i    (sysClk),
    .rst_i    (sysReset),
    .load_i   (start_c),
    .en_i     (state_q != ST_IDLE),
    .tick_c_o (tick_c)
  );

`ifdef AFE_SPI_REFRESH_EN
  logic [WORD_WIDTH-1:0]    shadow_q [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] valid_q;
  logic                     pend_q, pend_d;
  logic                     rf_act_q;
  logic [CHAN_W:0]          rf_next_q, rf_next_d;
  logic                     rf_tick_c, rf_found_c, rf_done_c;

  afe_spi_tick #(
    .PERIOD (REFRESH_CYCLES)
  ) u_refresh_tick (
    .clk_i    (sysClk),
    .rst_i    (sysReset),
    .load_i   (1'b0),
    .en_i     (1'b1),
    .tick_c_o (rf_tick_c)
  );

  // Lowest valid channel at or above the next refresh index
  always_comb begin
    rf_found_c = 1'b0;
    rf_idx_c   = '0;
    rf_word_c  = '0;
    for (int i = int'(CHANNEL_COUNT) - 1; i >= 0; i--) begin
      if (valid_q[i] && ((CHAN_W + 1)'(i) >= rf_next_q)) begin
        rf_found_c = 1'b1;
        rf_idx_c   = CHAN_W'(i);
        rf_word_c  = shadow_q[i];
      end
    end
  end

  // A CSR write accepted in the same IDLE cycle defers the refresh
  assign rf_start_c = (state_q == ST_IDLE) && pend_q && !accept_c && rf_found_c;
  assign rf_done_c  = (state_q == ST_IDLE) && pend_q && !accept_c && !rf_found_c;
  assign rf_busy_c  = rf_act_q;

  always_comb begin
    pend_d    = pend_q;
    rf_busy_d = rf_act_q;
    rf_next_d = rf_next_q;
    if (rf_start_c) begin
      rf_busy_d = 1'b1;
      rf_next_d = {1'b0, rf_idx_c} + (CHAN_W + 1)'(1);
    end
    if (rf_done_c) begin
      pend_d    = 1'b0;
      rf_busy_d = 1'b0;
      rf_next_d = '0;
    end
    if (rf_tick_c) pend_d = 1'b1;
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      pend_q    <= 1'b0;
      rf_act_q  <= 1'b0;
      rf_next_q <= '0;
      valid_q   <= '0;
      for (int i = 0; i < int'(CHANNEL_COUNT); i++) shadow_q[i] <= '0;
    end else begin
      pend_q    <= pend_d;
      rf_act_q  <= rf_busy_d;
      rf_next_q <= rf_next_d;
      for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
        if (accept_c && (wr_chan_c == CHAN_W'(i))) begin
          shadow_q[i] <= wr_word_c;
          valid_q[i]  <= 1'b1;
        end
      end
    end
  end
`else
  assign rf_busy_c  = 1'b0;
  assign rf_busy_d  = 1'b0;
  assign rf_start_c = 1'b0;
  assign rf_idx_c   = '0;
  assign rf_word_c  = '0;
`endif

  // Transfer FSM plus next values of the registered port outputs
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    ch_d    = ch_q;
    sel_d   = sel_q;
    bits_d  = bits_q;
    clk_d   = '0;
    sdi_d   = '0;
    le_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          word_d  = wr_word_c;
          ch_d    = wr_chan_c;
          shreg_d = wr_word_c;
          sel_d   = CHANNEL_COUNT'(1) << wr_chan_c;
        end else if (rf_start_c) begin
          ch_d    = rf_idx_c;
          shreg_d = rf_word_c;
          sel_d   = CHANNEL_COUNT'(1) << rf_idx_c;
        end
        if (start_c) begin
          state_d = ST_SETUP;
          bits_d  = '0;
        end
      end
      ST_SETUP:   if (tick_c) state_d = ST_CLK_HI;
      ST_CLK_HI: begin
        // Falling edge: advance to the next bit
        if (tick_c) begin
          state_d = ST_CLK_LO;
          shreg_d = shreg_q << 1;
          bits_d  = bits_q + BIT_W'(1);
        end
      end
      ST_CLK_LO: begin
        if (tick_c) begin
          state_d = (bits_q == BIT_W'(WORD_WIDTH)) ? ST_LE_HI : ST_CLK_HI;
        end
      end
      ST_LE_HI:   if (tick_c) state_d = ST_LE_HOLD;
      ST_LE_HOLD: if (tick_c) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (state_d == ST_CLK_HI) clk_d = sel_d;
    if ((state_d == ST_SETUP || state_d == ST_CLK_HI || state_d == ST_CLK_LO) &&
        shreg_d[WORD_WIDTH-1]) begin
      sdi_d = sel_d;
    end
    if (state_d == ST_LE_HI) le_d = sel_d;
  end

  // Sticky overrun: a dropped write beats a clear carried by the same write
  always_comb begin
    ovr_d = ovr_q;
    if (sysCsrStrobe && wr_clr_c) ovr_d = 1'b0;
    if (drop_c)                   ovr_d = 1'b1;

    status_d                       = '0;
    status_d[BUSY]                 = (state_d != ST_IDLE) || rf_busy_d;
    status_d[OVERRUN]              = ovr_d;
    status_d[CHAN_LSB +: CHAN_W]   = ch_d;
    status_d[WORD_WIDTH-1:0]       = word_d;
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      word_q   <= '0;
      ch_q     <= '0;
      sel_q    <= '0;
      bits_q   <= '0;
      ovr_q    <= 1'b0;
      clk_q    <= '0;
      sdi_q    <= '0;
      le_q     <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      word_q   <= word_d;
      ch_q     <= ch_d;
      sel_q    <= sel_d;
      bits_q   <= bits_d;
      ovr_q    <= ovr_d;
      clk_q    <= clk_d;
      sdi_q    <= sdi_d;
      le_q     <= le_d;
      status_q <= status_d;
    end
  end

  assign status = status_q;
  assign spiClk = clk_q;
  assign spiSdi = sdi_q;
  assign spiLe  = le_q;

endmodule

// File: doc/afe_spi_shifter.md
Name: afe_spi_shifter

Overview:
Drives the two AFE attenuator/switch serial ports (AFE_SPI_CLK/SDI/LE) from a processor CSR write in the system clock domain. A CSR write selects a channel and supplies a data word. The block shifts the word out MSB first at a divided SPI rate, then pulses the latch-enable. A busy/overrun status word is returned to the CSR read mux.

Parameters:
CLK_RATE, 99999001, sysClk frequency in Hz (SYSCLK_RATE from the top level).
SPI_RATE, 10000000, target SPI clock frequency in Hz.
WORD_WIDTH, 16, bits per AFE transfer.
CHANNEL_COUNT, 2, number of independent AFE ports (1..16).
REFRESH_CYCLES, 100000000, sysClk cycles between automatic refreshes (optional feature only).

Ports:
sysClk  input  1  system clock; all logic is in this domain.
sysReset  input  1  synchronous, active-high reset.
sysCsrStrobe  input  1  one-cycle write strobe for the data register.
sysGPIO_OUT  input  32  write data: [WORD_WIDTH-1:0] word, [27:24] channel index, [31] clear-overrun.
status  output  32  [31] busy, [30] overrun, [27:24] active channel, [WORD_WIDTH-1:0] last word accepted.
spiClk  output  CHANNEL_COUNT  AFE_SPI_CLK per channel.
spiSdi  output  CHANNEL_COUNT  AFE_SPI_SDI per channel.
spiLe  output  CHANNEL_COUNT  AFE_SPI_LE per channel.

Behaviour:
- HALF = ceil(CLK_RATE/(2*SPI_RATE)), minimum 1. This is a localparam. The half-period counter counts HALF-1 down to 0.
- Reset: all spi outputs 0; status 0; FSM in IDLE; shift register 0.
- Accepting a write:
  - Write accepted when sysCsrStrobe=1 and state==IDLE.
  - If the channel index >= CHANNEL_COUNT, the write is ignored and overrun is set.
  - On accept: latch word and channel; busy=1 on the next cycle; spiSdi[ch]=word MSB on the next cycle.
- FSM states and transitions:
  - IDLE -> SETUP, on accept.
  - SETUP: spiClk=0 for HALF cycles -> CLK_HI.
  - CLK_HI: spiClk[ch]=1 for HALF cycles -> CLK_LO.
  - CLK_LO: on entry, shift left and present the next bit on sdi. spiClk=0 for HALF cycles.
  - Bit counting: after WORD_WIDTH rising edges, CLK_LO -> LE_HI instead of CLK_HI.
  - LE_HI: spiLe[ch]=1, sdi=0, for HALF cycles -> LE_HOLD.
  - LE_HOLD: all low for HALF cycles -> IDLE, busy=0.
- Transaction length: (2*WORD_WIDTH+3)*HALF cycles from the cycle after the strobe.
- Outputs of unselected channels stay 0 throughout.
- Strobe while busy: the write is dropped and overrun=1 (sticky). The current transfer is unaffected.
- Clear-overrun (bit 31): clears overrun.
  - Allowed in any state.
  - If the same write is also dropped, set wins.
- Mid-transfer reset: outputs go to 0 on the next cycle. No LE pulse. Returns to IDLE.
- status is registered and updates one cycle after the state change.

Optional Feature:
Macro AFE_SPI_REFRESH_EN.
- Defined:
  - Per-channel shadow registers hold the last word accepted for each channel; reset value 0, with a valid bit.
  - A free-running counter reaches REFRESH_CYCLES-1, then wraps and raises a pending flag.
  - While IDLE with pending set, the block resends each valid channel in ascending order, one full transaction each, then clears pending.
  - A CSR strobe arriving during a refresh is treated as a strobe-while-busy.
  - A CSR write arriving in IDLE at the same cycle as pending has priority; the refresh follows.
- Undefined: no shadow registers, no counter, no refresh.

Decomposition:
- Package afe_spi_pkg:
  - FSM state enum.
  - status bit position constants (BUSY=31, OVERRUN=30, CHAN_LSB=24, CLR_OVR=31).
  - HALF computation function.
- One natural sub-module, afe_spi_tick: the half-period divider.
  - Inputs: load, enable.
  - Output: one-cycle tick every HALF cycles.
  - Reused by the refresh counter when the feature is enabled.

Test Plan:
- Basic transfer: CLK_RATE=100e6, SPI_RATE=10e6 (HALF=5); write 0x00A5_C3 with channel 0.
  - Sample SDI on rising spiClk[0]: 16 bits equal 0xA5C3, MSB first.
  - spiLe[0] high for exactly 5 cycles.
  - busy high for 175 cycles.
  - Channel 1 outputs stay 0.
- Channel 1 write of 0xFFFF: bits captured equal 0xFFFF on channel 1 only; status[27:24]=1.
- Strobe at cycle 50 of a transfer: first word completes unchanged; overrun=1; second word never shifted. Then write with bit31=1 -> overrun=0.
- Channel index 3 with CHANNEL_COUNT=2: no SPI activity; overrun=1; busy stays 0.
- sysReset asserted at cycle 80 of a transfer: all spi outputs 0 on the next cycle; no LE pulse; status=0; a new write then completes normally.
- With AFE_SPI_REFRESH_EN and REFRESH_CYCLES=1000: write ch0=0x1234, ch1=0x5678. At the counter wrap, the bench sees ch0 then ch1 transfers back to back with the same data. A CSR write issued during the refresh sets overrun.
